// File: rtl/mxbiu_rd_slave.sv
// MX Bus read responder: accepts one read at a time and serves it from a
// preloadable word array after WAIT_STATES wait cycles.
module mxbiu_rd_slave #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    MEM_DEPTH   = 256,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_txn_start,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_txn_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_ready,
    output logic                  rd_txn_cpl,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  busy
);

    localparam int                  IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [3:0]          WAIT_L  = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_WAIT,
        S_RD,
        S_DATA,
        S_CPL
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];
    logic                  rd_in_range;
    logic                  prog_in_range;

    // Full-width unsigned compare so out-of-range addresses never alias.
    assign rd_in_range   = {1'b0, addr_q}    < DEPTH_L;
    assign prog_in_range = {1'b0, prog_addr} < DEPTH_L;

    // Array has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (prog_we && prog_in_range) begin
            mem[prog_addr[IDX_W-1:0]] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wait_cnt   <= '0;
            rd_txn_ack <= 1'b0;
            rd_ready   <= 1'b0;
            rd_txn_cpl <= 1'b0;
            rd_data    <= '0;
            busy       <= 1'b0;
        end else begin
            rd_txn_ack <= 1'b0;
            rd_ready   <= 1'b0;
            rd_txn_cpl <= 1'b0;
            rd_data    <= '0;
            // Outputs are set on the edge that enters the state they belong to.
            case (state)
                S_IDLE: begin
                    if (rd_txn_start) begin
                        addr_q     <= rd_addr;
                        rd_txn_ack <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ACK;
                    end
                end
                S_ACK: begin
                    wait_cnt <= WAIT_L;
                    state    <= (WAIT_L != 4'd0) ? S_WAIT : S_RD;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= S_RD;
                    end
                end
                S_RD: begin
                    rd_data  <= rd_in_range ? mem[addr_q[IDX_W-1:0]] : ERR_DATA;
                    rd_ready <= 1'b1;
                    state    <= S_DATA;
                end
                S_DATA: begin
                    rd_txn_cpl <= 1'b1;
                    state      <= S_CPL;
                end
                S_CPL: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mxbiu_rd_slave.sv
// Bench for mxbiu_rd_slave: two instances (W=0/depth 16, W=3/depth 256),
// cycle-exact handshake checks plus a read-data scoreboard.
module tb_mxbiu_rd_slave;

    logic            clk;
    logic            rst;
    logic [1:0]      start, ack, ready, cpl, busy, we;
    logic [1:0][7:0] addr, rdata, paddr, pdata;
    logic            mon_en;
    int              n_tests;
    int              n_fail;
    logic [7:0]      q0[$];
    logic [7:0]      q1[$];

    mxbiu_rd_slave #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(16), .WAIT_STATES(0), .ERR_DATA(8'hEE)
    ) dut0 (
        .clk(clk), .rst(rst), .rd_txn_start(start[0]), .rd_addr(addr[0]),
        .rd_txn_ack(ack[0]), .rd_data(rdata[0]), .rd_ready(ready[0]), .rd_txn_cpl(cpl[0]),
        .prog_we(we[0]), .prog_addr(paddr[0]), .prog_data(pdata[0]), .busy(busy[0])
    );

    mxbiu_rd_slave #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .WAIT_STATES(3), .ERR_DATA(8'h00)
    ) dut1 (
        .clk(clk), .rst(rst), .rd_txn_start(start[1]), .rd_addr(addr[1]),
        .rd_txn_ack(ack[1]), .rd_data(rdata[1]), .rd_ready(ready[1]), .rd_txn_cpl(cpl[1]),
        .prog_we(we[1]), .prog_addr(paddr[1]), .prog_data(pdata[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        if (k == 0) q0.push_back(d);
        else        q1.push_back(d);
    endtask

    task automatic all_zero(input int k, input string tag);
        chk($sformatf("%s_ack%0d", tag, k),   32'(ack[k]),   0);
        chk($sformatf("%s_ready%0d", tag, k), 32'(ready[k]), 0);
        chk($sformatf("%s_cpl%0d", tag, k),   32'(cpl[k]),   0);
        chk($sformatf("%s_busy%0d", tag, k),  32'(busy[k]),  0);
    endtask

    task automatic prog(input int k, input logic [7:0] a, input logic [7:0] d);
        we[k]    = 1'b1;
        paddr[k] = a;
        pdata[k] = d;
        tick();
        we[k]    = 1'b0;
    endtask

    // One read: tick i is the edge E+i after the sampling edge E.
    task automatic txn(input int k, input logic [7:0] a, input logic [7:0] d, input int w,
                       input bit hold, input bit hz, input logic [7:0] hzd);
        start[k] = 1'b1;
        addr[k]  = a;
        push(k, d);
        for (int i = 0; i <= 3 + w; i++) begin
            tick();
            if (i == 0) begin
                if (!hold) start[k] = 1'b0;
                addr[k] = ~a;
            end
            chk($sformatf("ack%0d_a%0h_c%0d", k, a, i),   32'(ack[k]),   32'(i == 0));
            chk($sformatf("ready%0d_a%0h_c%0d", k, a, i), 32'(ready[k]), 32'(i == 2 + w));
            chk($sformatf("cpl%0d_a%0h_c%0d", k, a, i),   32'(cpl[k]),   32'(i == 3 + w));
            chk($sformatf("busy%0d_a%0h_c%0d", k, a, i),  32'(busy[k]),  1);
            if (hz && i == 1 + w) begin
                we[k]    = 1'b1;
                paddr[k] = a;
                pdata[k] = hzd;
            end
            if (hz && i == 2 + w) we[k] = 1'b0;
        end
        tick();
        chk($sformatf("idle_busy%0d_a%0h", k, a), 32'(busy[k]), 0);
        chk($sformatf("idle_ack%0d_a%0h", k, a),  32'(ack[k]),  0);
    endtask

    task automatic mon_one(input int k);
        logic [7:0] e;
        if (ready[k] === 1'b1) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                n_tests++;
                n_fail++;
                $error("FAIL rd_data%0d: observed %0h expected no read outstanding", k, rdata[k]);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("rd_data%0d", k), 32'(rdata[k]), 32'(e));
            end
        end else begin
            chk($sformatf("rd_data_quiet%0d", k), 32'(rdata[k]), 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(0);
            mon_one(1);
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mon_en  = 1'b0;
        rst     = 1'b0;
        start   = 2'b11;
        addr[0] = 8'h06;
        addr[1] = 8'h06;
        we      = '0;
        paddr   = '0;
        pdata   = '0;

        // Reset held with start asserted on both instances.
        for (int i = 0; i < 2; i++) begin
            tick();
            mon_en = 1'b1;
            all_zero(0, "rst");
            all_zero(1, "rst");
        end
        prog(0, 8'h06, 8'hA5);
        prog(0, 8'h0A, 8'h11);
        prog(0, 8'h0B, 8'h22);
        prog(0, 8'h0F, 8'h5C);
        prog(0, 8'h00, 8'h33);
        prog(1, 8'h06, 8'hA5);
        prog(1, 8'h80, 8'h3C);
        prog(1, 8'hFF, 8'h9E);
        all_zero(0, "rst_hold");
        all_zero(1, "rst_hold");

        // Release: start still high on dut0, ack on the first edge.
        start[1] = 1'b0;
        rst      = 1'b1;
        txn(0, 8'h06, 8'hA5, 0, 1'b0, 1'b0, 8'h00);

        // Wait states.
        txn(1, 8'h06, 8'hA5, 3, 1'b0, 1'b0, 8'h00);

        // Back-to-back with start held: acks 5 cycles apart.
        txn(0, 8'd10, 8'h11, 0, 1'b1, 1'b0, 8'h00);
        txn(0, 8'd11, 8'h22, 0, 1'b0, 1'b0, 8'h00);

        // Depth boundary on the 16-word instance.
        prog(0, 8'h10, 8'h77);
        txn(0, 8'h10, 8'hEE, 0, 1'b0, 1'b0, 8'h00);
        txn(0, 8'h0F, 8'h5C, 0, 1'b0, 1'b0, 8'h00);
        txn(0, 8'h00, 8'h33, 0, 1'b0, 1'b0, 8'h00);
        txn(0, 8'hFF, 8'hEE, 0, 1'b0, 1'b0, 8'h00);

        // Program write colliding with the RD-cycle read.
        txn(1, 8'h80, 8'h3C, 3, 1'b0, 1'b1, 8'hC3);
        txn(1, 8'h80, 8'hC3, 3, 1'b0, 1'b0, 8'h00);

        // Reset during WAIT aborts the transaction.
        start[1] = 1'b1;
        addr[1]  = 8'h06;
        tick();
        chk("abort_ack", 32'(ack[1]), 1);
        start[1] = 1'b0;
        tick();
        chk("abort_busy_wait", 32'(busy[1]), 1);
        rst = 1'b0;
        tick();
        all_zero(1, "abort_rst");
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            all_zero(1, "abort_after");
        end

        // Top of the full-depth array.
        txn(1, 8'hFF, 8'h9E, 3, 1'b0, 1'b0, 8'h00);

        tick();
        chk("sb_left0", 32'(q0.size()), 0);
        chk("sb_left1", 32'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
